// File: rtl/snake_pkg.sv
// Shared types and default geometry for the snake frame scheduler.
// Imported by the divider and by the scheduler top.
package snake_pkg;

  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned GUARD_LINE_DEF = 520;
  localparam int unsigned SPD_W_DEF      = 6;

  typedef enum logic [1:0] {
    S_WAIT,
    S_ARMED,
    S_GRANT
  } sched_state_t;

endpackage

// File: rtl/snake_frame_scheduler_frame_divider.sv
// Frame tick generation and frame-to-step division at a selectable speed.
// frame_tick and step_tick are both registered from line_hit, so they coincide.
module frame_divider
  import snake_pkg::*;
#(
  parameter int unsigned SPD_W = SPD_W_DEF
) (
  input  logic             VGA_clk,
  input  logic             reset,
  input  logic             line_hit,
  input  logic [SPD_W-1:0] speed_sel,
  input  logic             pause,
  input  logic             game_over,
  output logic             frame_tick,
  output logic             step_tick
);

  logic [SPD_W-1:0] frame_cnt;
  logic [SPD_W-1:0] spd;
  logic [SPD_W:0]   cnt_inc;
  logic             hold;
  logic             step_now;

  assign spd      = (speed_sel == '0) ? SPD_W'(1) : speed_sel;
  assign cnt_inc  = {1'b0, frame_cnt} + (SPD_W+1)'(1);
  assign hold     = pause || game_over;
  // >= rather than == so a speed lowered mid-count steps on the next frame.
  assign step_now = !hold && (cnt_inc >= {1'b0, spd});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      step_tick  <= 1'b0;
    end else begin
      frame_tick <= line_hit;
      step_tick  <= line_hit && step_now;
      if (line_hit) begin
        if (hold || step_now) frame_cnt <= '0;
        else                  frame_cnt <= cnt_inc[SPD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/snake_frame_scheduler.sv
// Frame-level controller: frame/step strobes and arbitration of the shared
// board-RAM port between the renderer (active video) and the game logic (blanking).
module snake_frame_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned GUARD_LINE = GUARD_LINE_DEF,
  parameter int unsigned SPD_W      = SPD_W_DEF
) (
  input  logic             VGA_clk,
  input  logic             reset,
  input  logic [9:0]       x_pos,
  input  logic [9:0]       y_pos,
  input  logic             display_enable,
  input  logic [SPD_W-1:0] speed_sel,
  input  logic             pause,
  input  logic             game_over,
  input  logic             logic_req,
  input  logic             logic_done,
  output logic             frame_tick,
  output logic             step_tick,
  output logic             logic_grant,
  output logic             render_grant,
  output logic             step_missed,
  output logic             overrun,
  output logic             overrun_flag
);

  logic line_hit;
  logic guard_hit;

  assign line_hit  = (y_pos == 10'(V_ACTIVE)) && (x_pos == '0);
  assign guard_hit = (y_pos == 10'(GUARD_LINE));

  frame_divider #(.SPD_W(SPD_W)) u_frame_divider (
    .VGA_clk    (VGA_clk),
    .reset      (reset),
    .line_hit   (line_hit),
    .speed_sel  (speed_sel),
    .pause      (pause),
    .game_over  (game_over),
    .frame_tick (frame_tick),
    .step_tick  (step_tick)
  );

  sched_state_t state, state_nxt;
  logic         missed_nxt;
  logic         overrun_nxt;

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt   = state;
    missed_nxt  = 1'b0;
    overrun_nxt = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (step_tick) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        // The guard line beats a late request: the step is simply lost.
        if (guard_hit) begin
          missed_nxt = 1'b1;
          state_nxt  = S_WAIT;
        end else if (logic_req) begin
          state_nxt  = S_GRANT;
        end
      end
      S_GRANT: begin
        // A done on the guard line still counts as finishing in time.
        if (logic_done) begin
          state_nxt   = S_WAIT;
        end else if (guard_hit) begin
          overrun_nxt = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Grants are registered from the next state so both flip on the same edge.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state        <= S_WAIT;
      logic_grant  <= 1'b0;
      render_grant <= 1'b1;
      step_missed  <= 1'b0;
      overrun      <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      logic_grant  <= (state_nxt == S_GRANT);
      render_grant <= (state_nxt != S_GRANT);
      step_missed  <= missed_nxt;
      overrun      <= overrun_nxt;
      overrun_flag <= overrun_flag | overrun_nxt;
    end
  end

  a_no_grant_in_video : assert property (
    @(posedge VGA_clk) disable iff (reset) display_enable |-> !logic_grant);

  a_grants_exclusive : assert property (
    @(posedge VGA_clk) disable iff (reset) render_grant != logic_grant);

endmodule

// File: tb/tb_snake_frame_scheduler.sv
// Scoreboard bench: a frame-level model predicts pulses and grant/flag levels
// per cycle; a negedge monitor pops and compares whatever the DUT presents.
module tb_snake_frame_scheduler;

  localparam int V_ACTIVE   = 480;
  localparam int GUARD_LINE = 520;
  localparam int SPD_W      = 6;
  localparam int H_TOTAL    = 2;
  localparam int V_TOTAL    = 525;
  localparam int GUARD_REL  = (GUARD_LINE - V_ACTIVE) * H_TOTAL;

  typedef enum int {EV_FRAME, EV_STEP, EV_MISSED, EV_OVERRUN} ev_kind_t;
  typedef struct {ev_kind_t kind; int cyc;} ev_t;
  typedef struct {logic grant; logic flag;} lvl_t;
  typedef enum int {P_NONE, P_HANDSHAKE, P_OVERRUN, P_DONE_AT_GUARD,
                    P_REQ_AT_GUARD, P_RESET_IN_GRANT} plan_t;

  logic             VGA_clk;
  logic             reset;
  logic [9:0]       x_pos, y_pos;
  logic             display_enable;
  logic [SPD_W-1:0] speed_sel;
  logic             pause, game_over, logic_req, logic_done;
  logic             frame_tick, step_tick, logic_grant, render_grant;
  logic             step_missed, overrun, overrun_flag;

  snake_frame_scheduler dut (
    .VGA_clk        (VGA_clk),
    .reset          (reset),
    .x_pos          (x_pos),
    .y_pos          (y_pos),
    .display_enable (display_enable),
    .speed_sel      (speed_sel),
    .pause          (pause),
    .game_over      (game_over),
    .logic_req      (logic_req),
    .logic_done     (logic_done),
    .frame_tick     (frame_tick),
    .step_tick      (step_tick),
    .logic_grant    (logic_grant),
    .render_grant   (render_grant),
    .step_missed    (step_missed),
    .overrun        (overrun),
    .overrun_flag   (overrun_flag)
  );

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ev_t  ev_q[$];
  lvl_t lvl_q[$];

  // Reference model state: frames since last step, step window, grant, sticky flag.
  int m_count = 0;
  bit m_step_prev = 0, m_armed = 0, m_grant = 0, m_flag = 0;
  int last_step_c = -1000000;

  // Per-frame stimulus plan.
  int    g_spd = 1;
  bit    g_pause = 0, g_go = 0, g_glitch = 0;
  plan_t g_plan = P_NONE;
  int    g_rd = 10, g_dd = 50;
  int    rst_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = n;
    ev_q.push_back(e);
  endfunction

  // Predicts the DUT response to the inputs that posedge n will sample.
  task automatic model_cycle(input int n);
    bit at_guard, at_line;
    lvl_t l;
    int spd;
    at_guard = (y_pos == 10'(GUARD_LINE));
    at_line  = (y_pos == 10'(V_ACTIVE)) && (x_pos == 10'd0);
    spd      = (speed_sel == '0) ? 1 : int'(speed_sel);
    if (reset) begin
      m_grant = 0; m_armed = 0; m_step_prev = 0; m_count = 0; m_flag = 0;
    end else begin
      if (m_grant) begin
        if (logic_done) m_grant = 0;
        else if (at_guard) begin
          m_grant = 0; m_flag = 1; push_ev(EV_OVERRUN, n);
        end
      end else if (m_armed) begin
        if (at_guard) begin
          m_armed = 0; push_ev(EV_MISSED, n);
        end else if (logic_req) begin
          m_armed = 0; m_grant = 1;
        end
      end else if (m_step_prev) begin
        m_armed = 1;
      end
      m_step_prev = 0;
      if (at_line) begin
        push_ev(EV_FRAME, n);
        if (pause || game_over) m_count = 0;
        else begin
          m_count++;
          if (m_count >= spd) begin
            m_count = 0; m_step_prev = 1; last_step_c = n; push_ev(EV_STEP, n);
          end
        end
      end
    end
    l.grant = m_grant;
    l.flag  = m_flag;
    lvl_q.push_back(l);
  endtask

  task automatic apply_plan(input int n);
    int rel;
    rel        = n - last_step_c;
    reset      = (rst_left > 0);
    if (rst_left > 0) rst_left--;
    speed_sel  = SPD_W'(g_spd);
    pause      = g_pause;
    game_over  = g_go;
    logic_req  = 1'b0;
    logic_done = 1'b0;
    if (rel >= 0 && rel <= GUARD_REL) begin
      case (g_plan)
        P_HANDSHAKE: begin
          logic_req  = (rel >= g_rd) && (rel <= g_rd + g_dd);
          logic_done = (rel == g_rd + g_dd);
        end
        P_OVERRUN:       logic_req = (rel >= g_rd);
        P_DONE_AT_GUARD: begin
          logic_req  = (rel >= g_rd);
          logic_done = (rel == GUARD_REL);
        end
        P_REQ_AT_GUARD:  logic_req = (rel == GUARD_REL);
        P_RESET_IN_GRANT: begin
          logic_req = (rel >= g_rd);
          if (rel == g_rd + g_dd) reset = 1'b1;
        end
        default: ;
      endcase
    end
    // A request during active video, with no step pending, must be ignored.
    if (g_glitch && y_pos == 10'd200 && x_pos == 10'd0) logic_req = 1'b1;
  endtask

  task automatic drive_cycle();
    @(posedge VGA_clk);
    cyc++;
    #1;
    if (x_pos == 10'(H_TOTAL - 1)) begin
      x_pos = 10'd0;
      y_pos = (y_pos == 10'(V_TOTAL - 1)) ? 10'd0 : y_pos + 10'd1;
    end else begin
      x_pos = x_pos + 10'd1;
    end
    display_enable = (y_pos < 10'(V_ACTIVE));
    apply_plan(cyc + 1);
    model_cycle(cyc + 1);
  endtask

  task automatic run_frame(input int spd, input bit p, input bit g, input plan_t pl,
                           input int rd, input int dd, input bit glitch);
    g_spd = spd; g_pause = p; g_go = g; g_plan = pl; g_rd = rd; g_dd = dd;
    g_glitch = glitch;
    last_step_c = -1000000;
    repeat (H_TOTAL * V_TOTAL) drive_cycle();
  endtask

  task automatic expect_ev(input ev_kind_t k);
    ev_t e;
    if (ev_q.size() == 0) begin
      check({k.name(), " unexpected pulse"}, 32'd1, 32'd0);
    end else begin
      e = ev_q.pop_front();
      check({k.name(), " kind"}, 32'(k), 32'(e.kind));
      check({k.name(), " cycle"}, 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge VGA_clk) begin
    lvl_t l;
    if (cyc > 0) begin
      if (lvl_q.size() == 0) begin
        check("level queue underflow", 32'd1, 32'd0);
      end else begin
        l = lvl_q.pop_front();
        check("logic_grant", 32'(logic_grant), 32'(l.grant));
        check("render_grant", 32'(render_grant), 32'(!l.grant));
        check("overrun_flag", 32'(overrun_flag), 32'(l.flag));
      end
      if (frame_tick)  expect_ev(EV_FRAME);
      if (step_tick)   expect_ev(EV_STEP);
      if (step_missed) expect_ev(EV_MISSED);
      if (overrun)     expect_ev(EV_OVERRUN);
    end
  end

  initial begin
    int rd, dd, kind;
    x_pos = 10'(H_TOTAL - 1);
    y_pos = 10'(V_TOTAL - 1);
    display_enable = 1'b1;
    reset = 1'b1; speed_sel = SPD_W'(1);
    pause = 1'b0; game_over = 1'b0; logic_req = 1'b0; logic_done = 1'b0;
    model_cycle(1);
    rst_left = 4;

    // Speed 1: a frame and a step every frame; no request -> step_missed.
    run_frame(1, 0, 0, P_NONE, 0, 0, 0);
    run_frame(1, 0, 0, P_NONE, 0, 0, 1);
    run_frame(1, 0, 0, P_NONE, 0, 0, 0);

    // Speed 4 for 12 frames: steps on frames 4, 8, 12, each with a handshake.
    for (int f = 1; f <= 12; f++) begin
      rd = (f == 4) ? 10 : $urandom_range(1, 60);
      dd = (f == 4) ? 50 : $urandom_range(1, GUARD_REL - 1 - rd);
      run_frame(4, 0, 0, P_HANDSHAKE, rd, dd, 0);
    end

    // Speed 4 for 5 frames then lowered to 2: next step on frame 6.
    for (int f = 1; f <= 5; f++) run_frame(4, 0, 0, P_NONE, 0, 0, 0);
    run_frame(2, 0, 0, P_NONE, 0, 0, 0);

    // Guard-line cases.
    run_frame(1, 0, 0, P_OVERRUN, 10, 0, 0);
    run_frame(1, 0, 0, P_DONE_AT_GUARD, 10, 0, 0);
    run_frame(1, 0, 0, P_REQ_AT_GUARD, 0, 0, 0);

    // Pause and game_over clear a partial count; speed 3 then needs 3 fresh frames.
    for (int f = 1; f <= 2; f++) run_frame(3, 0, 0, P_NONE, 0, 0, 0);
    for (int f = 1; f <= 5; f++) run_frame(3, 1, 0, P_HANDSHAKE, 10, 20, 0);
    for (int f = 1; f <= 3; f++) run_frame(3, 0, 0, P_NONE, 0, 0, 0);
    for (int f = 1; f <= 2; f++) run_frame(3, 0, 0, P_NONE, 0, 0, 0);
    for (int f = 1; f <= 5; f++) run_frame(3, 0, 1, P_HANDSHAKE, 10, 20, 0);
    for (int f = 1; f <= 3; f++) run_frame(3, 0, 0, P_NONE, 0, 0, 0);

    // speed_sel 0 behaves as 1.
    run_frame(0, 0, 0, P_HANDSHAKE, 5, 30, 0);
    run_frame(0, 0, 0, P_NONE, 0, 0, 0);

    // Reset while granted; also clears the sticky overrun_flag.
    run_frame(1, 0, 0, P_RESET_IN_GRANT, 10, 20, 0);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      kind = $urandom_range(0, 4);
      rd   = $urandom_range(1, 60);
      dd   = $urandom_range(1, GUARD_REL - 1 - rd);
      run_frame($urandom_range(0, 3), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                plan_t'(kind), rd, dd, $urandom_range(0, 1) == 1);
    end

    drive_cycle();
    @(negedge VGA_clk);
    #1;
    check("pending expected events", 32'(ev_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_frame_scheduler.md
# snake_frame_scheduler

Frame-level controller for the snake game datapath. Watches the VGA sync counters, produces a one-cycle frame tick at the start of vertical blanking, and divides frames into game-step strobes at a selectable speed. Arbitrates the single shared board-RAM port: the pixel renderer owns it during active video, and the game logic gets it only inside the blanking window. Sits between the VGA sync generator, the renderer and the snake update logic.

## Interface
- V_ACTIVE, 480, last visible line + 1; the frame tick fires when y_pos first equals this value.
- GUARD_LINE, 520, line at which any logic ownership is revoked; must satisfy V_ACTIVE < GUARD_LINE < last y_pos value.
- SPD_W, 6, width of the speed selector and frame counter.
- VGA_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- x_pos  in  10  horizontal counter from the sync generator.
- y_pos  in  10  vertical counter from the sync generator.
- display_enable  in  1  active-video flag; used only by the SVA that checks no logic grant during video.
- speed_sel  in  SPD_W  frames per game step; 0 is treated as 1.
- pause  in  1  level; suppresses steps.
- game_over  in  1  level; suppresses steps.
- logic_req  in  1  game logic requests the RAM port; held until logic_done.
- logic_done  in  1  one-cycle pulse: the logic has finished its step.
- frame_tick  out  1  one-cycle pulse per frame.
- step_tick  out  1  one-cycle pulse: the logic may perform one update.
- logic_grant  out  1  the game logic owns the RAM port.
- render_grant  out  1  the renderer owns the RAM port; always equals ~logic_grant.
- step_missed  out  1  one-cycle pulse: the step expired with no request.
- overrun  out  1  one-cycle pulse: the grant was revoked at GUARD_LINE.
- overrun_flag  out  1  sticky copy of overrun; cleared only by reset.

## Operation
- Blank detect: line_hit = (y_pos == V_ACTIVE) && (x_pos == 0). frame_tick is registered line_hit, so it asserts exactly once per frame.
- Speed: spd = (speed_sel == 0) ? 1 : speed_sel.
- Frame counter frame_cnt (SPD_W bits) updates on each frame_tick:
  - If pause or game_over: frame_cnt is held at 0 and no step is issued.
  - Else if frame_cnt + 1 >= spd: frame_cnt goes to 0 and step_tick is issued. The compare is >=, so lowering speed_sel mid-count steps on the next frame.
  - Else: frame_cnt increments.
- FSM states:
  - S_WAIT: renderer owns the port. On a frame_tick that steps, go to S_ARMED.
  - S_ARMED: renderer still owns the port.
    - logic_req goes to S_GRANT.
    - y_pos == GUARD_LINE with no request pulses step_missed and goes to S_WAIT.
  - S_GRANT: logic_grant = 1.
    - logic_done goes to S_WAIT.
    - y_pos == GUARD_LINE without logic_done pulses overrun, sets overrun_flag, and goes to S_WAIT.
- Precedence:
  - logic_done in the same cycle as the guard line: logic_done wins, no overrun.
  - logic_req in the same cycle as the guard line in S_ARMED: the guard wins, step_missed pulses, no grant.
- logic_req seen in S_WAIT is ignored. No grant is ever issued outside S_ARMED → S_GRANT.
- Only one step is issued per frame. A new step cannot arrive while the FSM is not in S_WAIT, because GUARD_LINE precedes the next frame_tick.

## Timing
- Reset values:
  - State S_WAIT, frame_cnt 0.
  - frame_tick, step_tick, logic_grant, step_missed, overrun, overrun_flag: all 0.
  - render_grant 1.
- Reset applied mid-grant drops logic_grant on the next edge.
- frame_tick: 1 cycle after line_hit.
- step_tick: same cycle as frame_tick.
- S_ARMED is entered on the edge after step_tick.
- logic_grant rises 1 cycle after logic_req is sampled in S_ARMED. It falls 1 cycle after logic_done, or 1 cycle after the GUARD_LINE sample.
- All outputs are registered. render_grant and logic_grant switch on the same edge and are never both high or both low.

## Structure
- Package snake_pkg holds:
  - The FSM state enum (S_WAIT, S_ARMED, S_GRANT).
  - The V_ACTIVE and GUARD_LINE defaults.
  - The SPD_W default.
- One sub-module: frame_divider, containing frame_cnt, the speed compare and step_tick generation. The FSM and arbitration stay in the top module.

## Test plan
- Frame tick: reset, then run 3 frames with speed_sel=1 → frame_tick at y_pos=480, x_pos=0 (+1 cycle), 3 pulses total, a step_tick each frame.
- Speed: speed_sel=4 for 12 frames → step_tick on frames 4, 8, 12. Change to 2 after frame 5 → next step at frame 6.
- Handshake: raise logic_req 10 cycles after step_tick, pulse logic_done 50 cycles later → grant rises 1 cycle after req, falls 1 cycle after done, render_grant is always its inverse.
- No request: step issued and logic_req never raised → step_missed pulses at y_pos=520 and the FSM returns to S_WAIT.
- Overrun: request granted, logic_done withheld → overrun at y_pos=520, grant dropped, overrun_flag stays 1 until reset. A done in the same cycle as the guard gives no overrun.
- pause=1 (and separately game_over=1) for 5 frames → frame_tick continues, no step_tick, frame_cnt=0. Reset asserted during S_GRANT → all outputs return to their reset values next cycle.
